stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/stopwatch_core_mod_counter.sv | 27 ++
 rtl/stopwatch_core.sv | 125 ++++++++++++
 tb/tb_stopwatch_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM states, default field moduli and field widths.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    localparam int MSEC_MOD_DEF = 1000;
    localparam int SEC_MOD_DEF  = 60;
    localparam int HOUR_MOD_DEF = 24;

    localparam int MSEC_W = 10;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

endpackage

// File: rtl/stopwatch_core_mod_counter.sv
// Modulus-N counter with enable and synchronous clear; carry is high in the cycle
// the counter rolls over from MOD-1 to 0, so counters can be chained by carry.
module mod_counter #(
    parameter int MOD = 10,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] value,
    output logic         carry
);

    always_comb begin
        carry = en && (value == W'(MOD - 1));
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (en) begin
            value <= carry ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: run/pause/clear FSM, chained msec/sec/min/hour counters,
// lap freeze latch and display muxing.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MSEC_MOD = MSEC_MOD_DEF,
    parameter int SEC_MOD  = SEC_MOD_DEF,
    parameter int HOUR_MOD = HOUR_MOD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_msec,
    input  logic              btn_run,
    input  logic              btn_clear,
    input  logic              btn_lap,
    output logic [MSEC_W-1:0] disp_msec,
    output logic [SEC_W-1:0]  disp_sec,
    output logic [MIN_W-1:0]  disp_min,
    output logic [HOUR_W-1:0] disp_hour,
    output logic              running,
    output logic              lap_active,
    output logic              wrap
);

    state_t state, state_next;

    logic tick_en, count_clr, lap_toggle;
    logic c_msec, c_sec, c_min, c_hour;

    logic [MSEC_W-1:0] live_msec, lap_msec;
    logic [SEC_W-1:0]  live_sec,  lap_sec;
    logic [MIN_W-1:0]  live_min,  lap_min;
    logic [HOUR_W-1:0] live_hour, lap_hour;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // btn_clear has priority over btn_run wherever it is honoured
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (!btn_clear && btn_run) state_next = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (btn_run) state_next = ST_PAUSED;
            end
            ST_PAUSED: begin
                if (btn_clear)    state_next = ST_IDLE;
                else if (btn_run) state_next = ST_RUNNING;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        running    = (state == ST_RUNNING);
        tick_en    = running && clk_msec;
        count_clr  = btn_clear && (state != ST_RUNNING);
        lap_toggle = btn_lap && running;
    end

    mod_counter #(.MOD(MSEC_MOD), .W(MSEC_W)) u_msec (
        .clk(clk), .reset(reset), .en(tick_en), .clr(count_clr),
        .value(live_msec), .carry(c_msec)
    );

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .clk(clk), .reset(reset), .en(c_msec), .clr(count_clr),
        .value(live_sec), .carry(c_sec)
    );

    mod_counter #(.MOD(SEC_MOD), .W(MIN_W)) u_min (
        .clk(clk), .reset(reset), .en(c_sec), .clr(count_clr),
        .value(live_min), .carry(c_min)
    );

    mod_counter #(.MOD(HOUR_MOD), .W(HOUR_W)) u_hour (
        .clk(clk), .reset(reset), .en(c_min), .clr(count_clr),
        .value(live_hour), .carry(c_hour)
    );

    // The latch captures the value visible before this edge, so a lap taken
    // together with a tick or a pause freezes the pre-update time.
    always_ff @(posedge clk) begin
        if (reset) begin
            lap_active <= 1'b0;
            wrap       <= 1'b0;
            lap_msec   <= '0;
            lap_sec    <= '0;
            lap_min    <= '0;
            lap_hour   <= '0;
        end else begin
            wrap <= c_hour;
            if (count_clr) begin
                lap_active <= 1'b0;
                lap_msec   <= '0;
                lap_sec    <= '0;
                lap_min    <= '0;
                lap_hour   <= '0;
            end else if (lap_toggle) begin
                lap_active <= !lap_active;
                if (!lap_active) begin
                    lap_msec <= live_msec;
                    lap_sec  <= live_sec;
                    lap_min  <= live_min;
                    lap_hour <= live_hour;
                end
            end
        end
    end

    always_comb begin
        disp_msec = lap_active ? lap_msec : live_msec;
        disp_sec  = lap_active ? lap_sec  : live_sec;
        disp_min  = lap_active ? lap_min  : live_min;
        disp_hour = lap_active ? lap_hour : live_hour;
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: table-driven single-cycle vectors plus
// long tick sequences, with a second small-modulus instance used for the full wrap.
module tb_stopwatch_core;

    typedef struct packed {
        logic       sel;
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [9:0] msec;
        logic       run;
        logic       lap;
        logic       wrap;
    } exp_t;

    typedef struct {
        logic  rst;
        logic  tick;
        logic  run;
        logic  clr;
        logic  lap;
        exp_t  exp;
        string name;
    } vec_t;

    logic clk;
    logic reset, clk_msec, btn_run, btn_clear, btn_lap;

    logic [9:0] m_msec, s_msec;
    logic [5:0] m_sec, m_min, s_sec, s_min;
    logic [4:0] m_hour, s_hour;
    logic       m_running, m_lap, m_wrap;
    logic       s_running, s_lap, s_wrap;

    exp_t  sb[$];
    string sb_names[$];
    vec_t  vecs[$];

    int num_checks = 0;
    int num_pass   = 0;

    stopwatch_core dut (
        .clk(clk), .reset(reset), .clk_msec(clk_msec),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .disp_msec(m_msec), .disp_sec(m_sec), .disp_min(m_min), .disp_hour(m_hour),
        .running(m_running), .lap_active(m_lap), .wrap(m_wrap)
    );

    stopwatch_core #(.MSEC_MOD(10), .SEC_MOD(6), .HOUR_MOD(3)) dut_small (
        .clk(clk), .reset(reset), .clk_msec(clk_msec),
        .btn_run(btn_run), .btn_clear(btn_clear), .btn_lap(btn_lap),
        .disp_msec(s_msec), .disp_sec(s_sec), .disp_min(s_min), .disp_hour(s_hour),
        .running(s_running), .lap_active(s_lap), .wrap(s_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic sel, input int h, input int m, input int s,
                                input int ms, input logic r, input logic l, input logic w);
        exp_t e;
        e.sel  = sel;
        e.hour = 5'(h);
        e.min  = 6'(m);
        e.sec  = 6'(s);
        e.msec = 10'(ms);
        e.run  = r;
        e.lap  = l;
        e.wrap = w;
        return e;
    endfunction

    function automatic vec_t mkVec(input logic rst, input logic tick, input logic run,
                                   input logic clr, input logic lap, input exp_t e,
                                   input string name);
        vec_t v;
        v.rst  = rst;
        v.tick = tick;
        v.run  = run;
        v.clr  = clr;
        v.lap  = lap;
        v.exp  = e;
        v.name = name;
        return v;
    endfunction

    task automatic checkOutput();
        exp_t        e;
        string       n;
        logic [30:0] act, req;
        logic [4:0]  ah;
        logic [5:0]  am, as;
        logic [9:0]  ams;
        logic        ar, al, aw;
        num_checks++;
        if (sb.size() == 0) begin
            $display("[TB] FAIL scoreboard: no expected entry queued");
            return;
        end
        e = sb.pop_front();
        n = sb_names.pop_front();
        if (e.sel) begin
            ah = s_hour; am = s_min; as = s_sec; ams = s_msec;
            ar = s_running; al = s_lap; aw = s_wrap;
        end else begin
            ah = m_hour; am = m_min; as = m_sec; ams = m_msec;
            ar = m_running; al = m_lap; aw = m_wrap;
        end
        act = {ah, am, as, ams, ar, al, aw};
        req = {e.hour, e.min, e.sec, e.msec, e.run, e.lap, e.wrap};
        if (act === req) begin
            num_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d:%0d:%0d.%0d run=%b lap=%b wrap=%b, expected %0d:%0d:%0d.%0d run=%b lap=%b wrap=%b",
                     n, ah, am, as, ams, ar, al, aw,
                     e.hour, e.min, e.sec, e.msec, e.run, e.lap, e.wrap);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic tick, input logic run,
                                 input logic clr, input logic lap, input exp_t e,
                                 input string name);
        reset     = rst;
        clk_msec  = tick;
        btn_run   = run;
        btn_clear = clr;
        btn_lap   = lap;
        sb.push_back(e);
        sb_names.push_back(name);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        clk_msec  = 1'b0;
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        checkOutput();
    endtask

    task automatic runTicks(input int n);
        for (int i = 0; i < n; i++) begin
            clk_msec = 1'b1;
            @(posedge clk);
            #1;
        end
        clk_msec = 1'b0;
    endtask

    initial begin
        reset = 1'b0; clk_msec = 1'b0; btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;

        //              rst   tick  run   clr   lap   expected (main DUT)
        vecs.push_back(mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0), "reset"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0), "idle_tick"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0), "idle_lap"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,1,0,0), "start"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,1,1,0,0), "tick1"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,2,0,0,0), "tick_and_pause"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2,0,0,0), "paused_tick"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2,0,0,0), "paused_lap"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0), "clear_beats_run"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,1,0,0), "restart"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,1,1,0,0), "tick_a"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0,1,1,0,0), "run_clear_ignored"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2,1,0,0), "tick_b"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,2,1,1,0), "lap_set"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2,1,1,0), "lap_hold1"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,2,1,1,0), "lap_hold2"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,4,1,0,0), "lap_release"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,4,0,1,0), "lap_and_pause"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,4,0,1,0), "paused_lap_hold"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,4,1,1,0), "resume_lapped"));
        vecs.push_back(mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0,0,0,0,4,1,1,0), "lapped_tick"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,4,0,1,0), "pause_keeps_lap"));
        vecs.push_back(mkVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0), "paused_clear"));
        vecs.push_back(mkVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0), "reset_again"));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].tick, vecs[i].run, vecs[i].clr,
                          vecs[i].lap, vecs[i].exp, vecs[i].name);
        end

        // Carry boundaries and the 1500-tick count from a fresh start
        applyStimulus(1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0), "seqA_reset");
        applyStimulus(0, 0, 1, 0, 0, mk(0,0,0,0,0,1,0,0), "seqA_run");
        runTicks(998);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,0,999,1,0,0), "at_0.999");
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,1,0,1,0,0), "msec_carry");
        runTicks(499);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,1,500,1,0,0), "count_1500");
        runTicks(58498);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,59,999,1,0,0), "at_59.999");
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,1,0,0,1,0,0), "sec_carry");

        // Lap freeze while live count continues, then pause and clear
        applyStimulus(1, 0, 0, 0, 0, mk(0,0,0,0,0,0,0,0), "seqB_reset");
        applyStimulus(0, 0, 1, 0, 0, mk(0,0,0,0,0,1,0,0), "seqB_run");
        runTicks(1999);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,2,0,1,0,0), "at_2.000");
        applyStimulus(0, 0, 0, 0, 1, mk(0,0,0,2,0,1,1,0), "lap_at_2.000");
        runTicks(499);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,2,0,1,1,0), "lap_frozen");
        applyStimulus(0, 0, 0, 0, 1, mk(0,0,0,2,500,1,0,0), "lap_shows_live");
        applyStimulus(0, 0, 1, 0, 0, mk(0,0,0,2,500,0,0,0), "pause_2.500");
        runTicks(99);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,2,500,0,0,0), "paused_100_ticks");
        applyStimulus(0, 0, 0, 1, 0, mk(0,0,0,0,0,0,0,0), "clear_to_idle");

        // Reset wins over a simultaneous tick and buttons mid-count
        applyStimulus(0, 0, 1, 0, 0, mk(0,0,0,0,0,1,0,0), "seqC_run");
        runTicks(5122);
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,5,123,1,0,0), "at_5.123");
        applyStimulus(0, 0, 0, 0, 1, mk(0,0,0,5,123,1,1,0), "lap_5.123");
        applyStimulus(1, 1, 1, 0, 1, mk(0,0,0,0,0,0,0,0), "reset_mid_count");
        applyStimulus(0, 1, 0, 0, 0, mk(0,0,0,0,0,0,0,0), "post_reset_tick");

        // Full wrap on the small instance: max is 2:05:05.9 after 1079 ticks
        applyStimulus(1, 0, 0, 0, 0, mk(1,0,0,0,0,0,0,0), "wrap_reset");
        applyStimulus(0, 0, 1, 0, 0, mk(1,0,0,0,0,1,0,0), "wrap_run");
        runTicks(1078);
        applyStimulus(0, 1, 0, 0, 0, mk(1,2,5,5,9,1,0,0), "all_max");
        applyStimulus(0, 1, 0, 0, 0, mk(1,0,0,0,0,1,0,1), "wrap_pulse");
        applyStimulus(0, 0, 0, 0, 0, mk(1,0,0,0,0,1,0,0), "wrap_single_cycle");

        $display("%0d/%0d checks passed", num_pass, num_checks);
        $finish;
    end

endmodule
